// File: rtl/proton_pkg.sv
// Shared constants and types for the PROTON fetch stage.
package proton_pkg;

  localparam int DATA_LENGTH   = 32;
  localparam int ADDRESS_LINES = 20;

  localparam logic [DATA_LENGTH-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [DATA_LENGTH-1:0] pc;
    logic [DATA_LENGTH-1:0] ir;
  } fetch_entry_t;

endpackage

// File: rtl/proton_fetch_fifo.sv
// Generic DEPTH-entry circular buffer with push, pop, flush and occupancy.
module proton_fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push at full is only accepted when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/proton_fetch_queue.sv
// PROTON fetch/prefetch stage: PC, IMEM request logic and a decode-side queue.
// Optional macro PROTON_FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module proton_fetch_queue #(
  parameter int                     DATA_LENGTH   = proton_pkg::DATA_LENGTH,
  parameter int                     ADDRESS_LINES = proton_pkg::ADDRESS_LINES,
  parameter int                     DEPTH         = 4,
  parameter logic [DATA_LENGTH-1:0] RESET_PC      = '0
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  output logic                     IMEM_REQ,
  output logic [ADDRESS_LINES-1:0] IMEM_ADDR,
  input  logic [DATA_LENGTH-1:0]   IMEM_DATA,
  input  logic                     REDIRECT,
  input  logic [DATA_LENGTH-1:0]   REDIRECT_PC,
  input  logic                     HALT,
  output logic                     ID_VALID,
  output logic [DATA_LENGTH-1:0]   ID_IR,
  output logic [DATA_LENGTH-1:0]   ID_PC,
  input  logic                     ID_READY,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [DATA_LENGTH-1:0] pc;
    logic [DATA_LENGTH-1:0] ir;
  } entry_t;

  logic [DATA_LENGTH-1:0] pc;
  logic [DATA_LENGTH-1:0] pc_pipe;
  logic                   inflight;
  logic                   req;
  logic [CNT_W:0]         occupancy;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CNT_W-1:0]       fifo_count;
  entry_t                 fifo_wdata;
  entry_t                 fifo_rdata;

  // Every outstanding read owns a queue slot, so a response can always be written.
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight};
  assign req       = RST_N && !HALT && !REDIRECT && (occupancy < (CNT_W + 1)'(DEPTH));

  assign IMEM_REQ   = req;
  assign IMEM_ADDR  = pc[ADDRESS_LINES-1:0];
  assign COUNT      = fifo_count;
  assign fifo_wdata = '{pc: pc_pipe, ir: IMEM_DATA};
  assign fifo_pop   = !fifo_empty && ID_READY && !REDIRECT;

`ifdef PROTON_FETCH_BYPASS_EN
  logic bypass_hit;

  assign bypass_hit = fifo_empty && inflight && !REDIRECT;
  assign fifo_push  = inflight && !REDIRECT && !(bypass_hit && ID_READY);
  assign ID_VALID   = !fifo_empty || bypass_hit;
  assign ID_IR      = bypass_hit ? IMEM_DATA : fifo_rdata.ir;
  assign ID_PC      = bypass_hit ? pc_pipe   : fifo_rdata.pc;
`else
  assign fifo_push  = inflight && !REDIRECT;
  assign ID_VALID   = !fifo_empty;
  assign ID_IR      = fifo_rdata.ir;
  assign ID_PC      = fifo_rdata.pc;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc       <= RESET_PC;
      pc_pipe  <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= req;
      if (REDIRECT) begin
        pc <= REDIRECT_PC;
      end else if (req) begin
        pc      <= pc + DATA_LENGTH'(1);
        pc_pipe <= pc;
      end
    end
  end

  proton_fetch_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (REDIRECT),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  a_no_overflow: assert property (@(posedge CLK) disable iff (!RST_N)
    !(fifo_push && fifo_full && !fifo_pop));

endmodule
